ip_rx_header_parser: RTL and testbench

- Receive-side counterpart of the IPv4 header checksum generator.
- Consumes the IPv4 byte stream delivered by the Ethernet RX path after EtherType 0x0800 is stripped.
- Parses and validates the IPv4 header: version, IHL, one's-complement checksum, destination address, fragmentation.
- Exposes the header fields and forwards exactly total_length − IHL*4 payload bytes to the UDP layer; Ethernet padding and rejected datagrams are discarded.

---
 rtl/ip_rx_header_parser.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_ip_rx_header_parser.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_rx_header_parser.sv
// ip_rx_header_parser
//   Receive-side IPv4 header parser. Takes the byte stream that follows the
//   stripped EtherType 0x0800, validates the header (version, IHL, header
//   checksum, destination address, fragmentation, length) and forwards exactly
//   total_length - IHL*4 payload bytes. Ethernet padding and rejected
//   datagrams are discarded.
//
//   Build option: define IP_RX_BROADCAST_EN to also accept dst 255.255.255.255.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   rx_data/rx_valid   input byte stream; only rx_valid cycles advance state
//   rx_sof/rx_eof      first header byte / last byte of the Ethernet frame
//   hdr_done           one-cycle pulse, header accepted
//   hdr_err/err_code   one-cycle pulse with reject reason (1..7)
//   src_ip, dst_ip,
//   protocol,
//   total_length       header fields, stable from hdr_done until next rx_sof
//   pl_data/pl_valid   payload byte, one cycle behind rx_data
//   pl_last            final payload byte
//   busy               frame in progress (FSM not in IDLE)
//
// state | meaning
// IDLE  | waiting for rx_sof, other bytes ignored
// HDR   | header bytes latched by index and summed
// PAY   | payload bytes forwarded, length counter running
// DROP  | discarding bytes until rx_eof

module ip_rx_header_parser #(
   parameter logic [31:0] LOCAL_IP = 32'hC0A80003,
   parameter int unsigned ACC_W    = 21
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_sof,
   input  logic        rx_eof,
   output logic        hdr_done,
   output logic        hdr_err,
   output logic [2:0]  err_code,
   output logic [31:0] src_ip,
   output logic [31:0] dst_ip,
   output logic [7:0]  protocol,
   output logic [15:0] total_length,
   output logic [7:0]  pl_data,
   output logic        pl_valid,
   output logic        pl_last,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_PAY  = 2'd2,
      S_DROP = 2'd3
   } state_t;

   localparam logic [2:0] ERR_VER   = 3'd1;
   localparam logic [2:0] ERR_IHL   = 3'd2;
   localparam logic [2:0] ERR_CSUM  = 3'd3;
   localparam logic [2:0] ERR_DST   = 3'd4;
   localparam logic [2:0] ERR_FRAG  = 3'd5;
   localparam logic [2:0] ERR_TRUNC = 3'd6;
   localparam logic [2:0] ERR_LEN   = 3'd7;

   state_t           state, state_n;
   logic [5:0]       idx, idx_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [7:0]       hi, hi_n;
   logic [15:0]      cnt, cnt_n;
   logic             done_n, err_n;
   logic [2:0]       code_n;
   logic             pl_valid_n, pl_last_n;
   logic [7:0]       pl_data_n;

   logic [3:0]       version_r;
   logic [3:0]       ihl_r;
   logic             frag_mf;
   logic [12:0]      frag_off;

   logic             hdr_byte;
   logic [5:0]       idx_cur;
   logic [5:0]       last_idx;
   logic [15:0]      hdr_len;
   logic [15:0]      pay_len;
   logic [ACC_W-1:0] sum_full;
   logic [16:0]      fold1;
   logic [15:0]      fold2;
   logic [31:0]      dst_now;
   logic             dst_ok;
   logic [2:0]       verdict;

   // A header byte is either the rx_sof byte (index 0 from any state) or any
   // valid byte while in HDR.
   assign hdr_byte = rx_valid && (rx_sof || (state == S_HDR));
   assign idx_cur  = rx_sof ? 6'd0 : idx;

   assign last_idx = {ihl_r, 2'b00} - 6'd1;
   assign hdr_len  = {10'd0, ihl_r, 2'b00};
   assign pay_len  = total_length - hdr_len;

   // The last header word is added combinationally so the verdict can be
   // registered on the last header byte itself.
   assign sum_full = acc + {{(ACC_W-16){1'b0}}, hi, rx_data};
   assign fold1    = {1'b0, sum_full[15:0]} + 17'(sum_full[ACC_W-1:16]);
   assign fold2    = fold1[15:0] + {15'd0, fold1[16]};

   // With IHL=5 the last dst byte arrives together with the verdict.
   assign dst_now  = (idx == 6'd19) ? {dst_ip[23:0], rx_data} : dst_ip;

`ifdef IP_RX_BROADCAST_EN
   assign dst_ok = (dst_now == LOCAL_IP) || (dst_now == 32'hFFFF_FFFF);
`else
   assign dst_ok = (dst_now == LOCAL_IP);
`endif

   always_comb begin
      verdict = 3'd0;
      if (version_r != 4'd4)
         verdict = ERR_VER;
      else if (fold2 != 16'hFFFF)
         verdict = ERR_CSUM;
      else if (!dst_ok)
         verdict = ERR_DST;
      else if (frag_mf || (frag_off != 13'd0))
         verdict = ERR_FRAG;
      else if (rx_eof && (total_length > hdr_len))
         verdict = ERR_TRUNC;
      else if (total_length < hdr_len)
         verdict = ERR_LEN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= 6'd0;
         acc      <= '0;
         hi       <= 8'd0;
         cnt      <= 16'd0;
         hdr_done <= 1'b0;
         hdr_err  <= 1'b0;
         err_code <= 3'd0;
         pl_data  <= 8'd0;
         pl_valid <= 1'b0;
         pl_last  <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         acc      <= acc_n;
         hi       <= hi_n;
         cnt      <= cnt_n;
         hdr_done <= done_n;
         hdr_err  <= err_n;
         err_code <= code_n;
         pl_data  <= pl_data_n;
         pl_valid <= pl_valid_n;
         pl_last  <= pl_last_n;
      end
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      acc_n      = acc;
      hi_n       = hi;
      cnt_n      = cnt;
      done_n     = 1'b0;
      err_n      = 1'b0;
      code_n     = 3'd0;
      pl_valid_n = 1'b0;
      pl_last_n  = 1'b0;
      pl_data_n  = pl_data;

      if (rx_valid && rx_sof) begin
         // Restart on a new header; an interrupted payload is reported.
         if (state == S_PAY) begin
            err_n  = 1'b1;
            code_n = ERR_TRUNC;
         end
         idx_n   = 6'd1;
         acc_n   = '0;
         hi_n    = rx_data;
         state_n = S_HDR;
         if (rx_data[3:0] < 4'd5) begin
            err_n   = 1'b1;
            code_n  = (rx_data[7:4] != 4'd4) ? ERR_VER : ERR_IHL;
            idx_n   = 6'd0;
            state_n = rx_eof ? S_IDLE : S_DROP;
         end else if (rx_eof) begin
            err_n   = 1'b1;
            code_n  = ERR_TRUNC;
            idx_n   = 6'd0;
            state_n = S_IDLE;
         end
      end else if (rx_valid) begin
         case (state)
            S_HDR: begin
               idx_n = idx + 6'd1;
               if (!idx[0])
                  hi_n = rx_data;
               else
                  acc_n = sum_full;
               if (idx == last_idx) begin
                  idx_n = 6'd0;
                  acc_n = '0;
                  if (verdict == 3'd0) begin
                     done_n = 1'b1;
                     cnt_n  = pay_len;
                     if (pay_len == 16'd0)
                        state_n = rx_eof ? S_IDLE : S_DROP;
                     else
                        state_n = S_PAY;
                  end else begin
                     err_n   = 1'b1;
                     code_n  = verdict;
                     state_n = rx_eof ? S_IDLE : S_DROP;
                  end
               end else if (rx_eof) begin
                  err_n   = 1'b1;
                  code_n  = ERR_TRUNC;
                  idx_n   = 6'd0;
                  acc_n   = '0;
                  state_n = S_IDLE;
               end
            end
            S_PAY: begin
               pl_valid_n = 1'b1;
               pl_data_n  = rx_data;
               cnt_n      = cnt - 16'd1;
               if (cnt == 16'd1) begin
                  pl_last_n = 1'b1;
                  state_n   = rx_eof ? S_IDLE : S_DROP;
               end else if (rx_eof) begin
                  // Frame ended short of total_length.
                  pl_last_n = 1'b1;
                  err_n     = 1'b1;
                  code_n    = ERR_TRUNC;
                  state_n   = S_IDLE;
               end
            end
            S_DROP: begin
               if (rx_eof)
                  state_n = S_IDLE;
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   // Header field capture by byte index.
   always_ff @(posedge clk) begin
      if (rst) begin
         version_r    <= 4'd0;
         ihl_r        <= 4'd0;
         frag_mf      <= 1'b0;
         frag_off     <= 13'd0;
         src_ip       <= 32'd0;
         dst_ip       <= 32'd0;
         protocol     <= 8'd0;
         total_length <= 16'd0;
      end else if (hdr_byte) begin
         case (idx_cur)
            6'd0: begin
               version_r <= rx_data[7:4];
               ihl_r     <= rx_data[3:0];
            end
            6'd2:  total_length[15:8] <= rx_data;
            6'd3:  total_length[7:0]  <= rx_data;
            6'd6: begin
               frag_mf        <= rx_data[5];
               frag_off[12:8] <= rx_data[4:0];
            end
            6'd7:  frag_off[7:0] <= rx_data;
            6'd9:  protocol      <= rx_data;
            6'd12, 6'd13, 6'd14, 6'd15: src_ip <= {src_ip[23:0], rx_data};
            6'd16, 6'd17, 6'd18, 6'd19: dst_ip <= {dst_ip[23:0], rx_data};
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ip_rx_header_parser.sv
module tb_ip_rx_header_parser;

   localparam logic [31:0] LOCAL_IP = 32'hC0A80003;
   localparam logic [31:0] SRC_IP   = 32'hC0A80002;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_sof, rx_eof;
   logic        hdr_done, hdr_err;
   logic [2:0]  err_code;
   logic [31:0] src_ip, dst_ip;
   logic [7:0]  protocol;
   logic [15:0] total_length;
   logic [7:0]  pl_data;
   logic        pl_valid, pl_last, busy;

   always #5 clk = ~clk;

   ip_rx_header_parser #(.LOCAL_IP(LOCAL_IP), .ACC_W(21)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
      .hdr_done(hdr_done), .hdr_err(hdr_err), .err_code(err_code),
      .src_ip(src_ip), .dst_ip(dst_ip), .protocol(protocol),
      .total_length(total_length),
      .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .busy(busy)
   );

   typedef struct packed {
      logic [2:0]  code;   // 0 = hdr_done, else expected err_code
      logic [31:0] src;
      logic [31:0] dst;
      logic [7:0]  proto;
      logic [15:0] tlen;
   } ev_t;

   ev_t        exp_ev[$];
   logic [8:0] exp_pl[$];   // {last, data}
   logic [7:0] hdr_q[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   bit         gap_mode = 1'b0;
   ev_t        mon_e;
   logic [8:0] mon_p;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic ev_t ev_done(input logic [31:0] dst, input logic [15:0] tlen);
      ev_t e;
      e.code = 3'd0; e.src = SRC_IP; e.dst = dst; e.proto = 8'h11; e.tlen = tlen;
      return e;
   endfunction

   function automatic ev_t ev_err(input logic [2:0] code);
      ev_t e;
      e = '0;
      e.code = code;
      return e;
   endfunction

   function automatic logic [7:0] pay_byte(input int j);
      return 8'((j * 13 + 5) & 255);
   endfunction

   // Scoreboard: compare DUT output events against expectations, in order.
   always @(negedge clk) begin
      if (!rst) begin
         if (hdr_done || hdr_err) begin
            if (exp_ev.size() == 0) begin
               check("unexpected_hdr_event", {29'd0, hdr_done, hdr_err, 1'b0}, 32'd0);
            end else begin
               mon_e = exp_ev.pop_front();
               check("hdr_done_kind", {31'd0, hdr_done}, {31'd0, mon_e.code == 3'd0});
               check("hdr_err_kind", {31'd0, hdr_err}, {31'd0, mon_e.code != 3'd0});
               if (hdr_err)
                  check("err_code", {29'd0, err_code}, {29'd0, mon_e.code});
               if (hdr_done) begin
                  check("src_ip", src_ip, mon_e.src);
                  check("dst_ip", dst_ip, mon_e.dst);
                  check("protocol", {24'd0, protocol}, {24'd0, mon_e.proto});
                  check("total_length", {16'd0, total_length}, {16'd0, mon_e.tlen});
               end
            end
         end
         if (pl_valid) begin
            if (exp_pl.size() == 0) begin
               check("unexpected_pl_valid", {31'd0, pl_valid}, 32'd0);
            end else begin
               mon_p = exp_pl.pop_front();
               check("pl_data", {24'd0, pl_data}, {24'd0, mon_p[7:0]});
               check("pl_last", {31'd0, pl_last}, {31'd0, mon_p[8]});
            end
         end else if (pl_last) begin
            check("pl_last_without_valid", {31'd0, pl_last}, 32'd0);
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input bit sof, input bit eof);
      @(negedge clk);
      rx_data = d; rx_valid = 1'b1; rx_sof = sof; rx_eof = eof;
      if (gap_mode) begin
         repeat (2) begin
            @(negedge clk);
            rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
      end
   endtask

   task automatic send_frame(input int n_pay, input int n_pad, input int n_fwd,
                             input bit last_exp, input bit with_eof);
      int total;
      int k;
      logic [7:0] d;
      total = hdr_q.size() + n_pay + n_pad;
      k = 0;
      for (int i = 0; i < hdr_q.size(); i++) begin
         send_byte(hdr_q[i], i == 0, with_eof && (k == total - 1));
         k++;
      end
      for (int j = 0; j < n_pay; j++) begin
         d = pay_byte(j);
         if (j < n_fwd) exp_pl.push_back({last_exp && (j == n_fwd - 1), d});
         send_byte(d, 1'b0, with_eof && (k == total - 1));
         k++;
      end
      for (int j = 0; j < n_pad; j++) begin
         send_byte(8'h00, 1'b0, with_eof && (k == total - 1));
         k++;
      end
   endtask

   task automatic end_frame(input string tag);
      idle(4);
      check({tag, "_events_pending"}, exp_ev.size(), 32'd0);
      check({tag, "_payload_pending"}, exp_pl.size(), 32'd0);
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      exp_ev.delete();
      exp_pl.delete();
   endtask

   task automatic load_frame_a();
      hdr_q = '{8'h45, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11,
                8'hF9, 8'h64, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'hC0, 8'hA8, 8'h00, 8'h03};
   endtask

   task automatic build_hdr(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tlen,
                            input logic [7:0] b6, input logic [31:0] dst);
      logic [31:0] s;
      logic [15:0] cs;
      hdr_q.delete();
      hdr_q.push_back({ver, ihl}); hdr_q.push_back(8'h00);
      hdr_q.push_back(tlen[15:8]); hdr_q.push_back(tlen[7:0]);
      hdr_q.push_back(8'h00); hdr_q.push_back(8'h00);
      hdr_q.push_back(b6); hdr_q.push_back(8'h00);
      hdr_q.push_back(8'h40); hdr_q.push_back(8'h11);
      hdr_q.push_back(8'h00); hdr_q.push_back(8'h00);
      hdr_q.push_back(SRC_IP[31:24]); hdr_q.push_back(SRC_IP[23:16]);
      hdr_q.push_back(SRC_IP[15:8]);  hdr_q.push_back(SRC_IP[7:0]);
      hdr_q.push_back(dst[31:24]); hdr_q.push_back(dst[23:16]);
      hdr_q.push_back(dst[15:8]);  hdr_q.push_back(dst[7:0]);
      for (int i = 5; i < int'(ihl); i++) repeat (4) hdr_q.push_back(8'h00);
      s = 32'd0;
      for (int i = 0; i + 1 < hdr_q.size(); i += 2) s = s + {16'd0, hdr_q[i], hdr_q[i+1]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      cs = ~s[15:0];
      hdr_q[10] = cs[15:8];
      hdr_q[11] = cs[7:0];
   endtask

   initial begin
      rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_hdr_done", {31'd0, hdr_done}, 32'd0);
      check("rst_hdr_err", {31'd0, hdr_err}, 32'd0);
      check("rst_err_code", {29'd0, err_code}, 32'd0);
      check("rst_src_ip", src_ip, 32'd0);
      check("rst_dst_ip", dst_ip, 32'd0);
      check("rst_protocol", {24'd0, protocol}, 32'd0);
      check("rst_total_length", {16'd0, total_length}, 32'd0);
      check("rst_pl_valid", {31'd0, pl_valid}, 32'd0);
      check("rst_pl_data", {24'd0, pl_data}, 32'd0);
      check("rst_pl_last", {31'd0, pl_last}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      idle(2);

      // Reference frame: 31 payload bytes, 15 pad bytes.
      load_frame_a();
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0033));
      send_frame(31, 15, 31, 1'b1, 1'b1);
      end_frame("frame_a");

      // Corrupted checksum.
      load_frame_a();
      hdr_q[11] = 8'h65;
      exp_ev.push_back(ev_err(3'd3));
      send_frame(31, 15, 0, 1'b0, 1'b1);
      end_frame("csum_bad");

      // Foreign destination with valid checksum.
      build_hdr(4'd4, 4'd5, 16'h0033, 8'h00, 32'hC0A80004);
      exp_ev.push_back(ev_err(3'd4));
      send_frame(31, 15, 0, 1'b0, 1'b1);
      end_frame("dst_other");

      // Broadcast destination.
      build_hdr(4'd4, 4'd5, 16'h0033, 8'h00, 32'hFFFFFFFF);
`ifdef IP_RX_BROADCAST_EN
      exp_ev.push_back(ev_done(32'hFFFFFFFF, 16'h0033));
      send_frame(31, 15, 31, 1'b1, 1'b1);
`else
      exp_ev.push_back(ev_err(3'd4));
      send_frame(31, 15, 0, 1'b0, 1'b1);
`endif
      end_frame("broadcast");

      // IHL=6 with one zero option word: 51 - 24 = 27 payload bytes.
      build_hdr(4'd4, 4'd6, 16'h0033, 8'h00, LOCAL_IP);
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0033));
      send_frame(27, 9, 27, 1'b1, 1'b1);
      end_frame("ihl6");

      // Frame ends after 10 of 31 payload bytes.
      load_frame_a();
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0033));
      exp_ev.push_back(ev_err(3'd6));
      send_frame(10, 0, 10, 1'b1, 1'b1);
      end_frame("trunc_eof");

      // New rx_sof in the middle of a payload, then a clean frame.
      load_frame_a();
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0033));
      send_frame(5, 0, 5, 1'b0, 1'b0);
      exp_ev.push_back(ev_err(3'd6));
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0033));
      send_frame(31, 15, 31, 1'b1, 1'b1);
      end_frame("sof_abort");

      // Reference frame again with 1-0-0-1 valid pattern.
      gap_mode = 1'b1;
      load_frame_a();
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0033));
      send_frame(31, 15, 31, 1'b1, 1'b1);
      end_frame("gaps");
      gap_mode = 1'b0;

      // More-fragments flag set.
      build_hdr(4'd4, 4'd5, 16'h0033, 8'h20, LOCAL_IP);
      exp_ev.push_back(ev_err(3'd5));
      send_frame(31, 15, 0, 1'b0, 1'b1);
      end_frame("frag_mf");

      // Wrong version.
      build_hdr(4'd6, 4'd5, 16'h0033, 8'h00, LOCAL_IP);
      exp_ev.push_back(ev_err(3'd1));
      send_frame(31, 15, 0, 1'b0, 1'b1);
      end_frame("version");

      // IHL below minimum: rejected at byte 0.
      build_hdr(4'd4, 4'd4, 16'h0033, 8'h00, LOCAL_IP);
      exp_ev.push_back(ev_err(3'd2));
      send_frame(0, 10, 0, 1'b0, 1'b1);
      end_frame("ihl_small");

      // total_length shorter than the header.
      build_hdr(4'd4, 4'd5, 16'h0010, 8'h00, LOCAL_IP);
      exp_ev.push_back(ev_err(3'd7));
      send_frame(0, 26, 0, 1'b0, 1'b1);
      end_frame("len_short");

      // Header-only datagram followed by padding.
      build_hdr(4'd4, 4'd5, 16'h0014, 8'h00, LOCAL_IP);
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0014));
      send_frame(0, 26, 0, 1'b0, 1'b1);
      end_frame("zero_payload");

      // Reset while forwarding payload.
      load_frame_a();
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0033));
      send_frame(5, 0, 5, 1'b0, 1'b0);
      idle(2);
      check("busy_in_payload", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_pl_valid", {31'd0, pl_valid}, 32'd0);
      check("midrst_pl_data", {24'd0, pl_data}, 32'd0);
      check("midrst_src_ip", src_ip, 32'd0);
      check("midrst_dst_ip", dst_ip, 32'd0);
      check("midrst_total_length", {16'd0, total_length}, 32'd0);
      check("midrst_protocol", {24'd0, protocol}, 32'd0);
      check("midrst_hdr_done", {31'd0, hdr_done}, 32'd0);
      check("midrst_hdr_err", {31'd0, hdr_err}, 32'd0);
      rst = 1'b0;
      end_frame("mid_reset");

      // Recovery after reset.
      load_frame_a();
      exp_ev.push_back(ev_done(LOCAL_IP, 16'h0033));
      send_frame(31, 15, 31, 1'b1, 1'b1);
      end_frame("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
